// File: rtl/dom_and_pipelined.sv
// Two-stage Domain-Oriented-Masking AND gadget with valid/ready on both sides.
// Optional build macro DOM_RAND_LFSR_EN replaces rand_in with an internal LFSR.
module dom_and_pipelined #(
  parameter  int WIDTH  = 8,
  parameter  int SHARES = 2,
  parameter  int CNT_W  = 16,
  localparam int RBITS  = WIDTH * SHARES * (SHARES - 1) / 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SHARES*WIDTH-1:0] a_sh,
  input  logic [SHARES*WIDTH-1:0] b_sh,
  input  logic [RBITS-1:0]        rand_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SHARES*WIDTH-1:0] q_sh,
  output logic [CNT_W-1:0]        op_count
);

  localparam int TERMS = SHARES * SHARES;

  if (SHARES != 2 && SHARES != 3) begin : g_bad_shares
    $error("dom_and_pipelined: SHARES must be 2 or 3");
  end

  // Slice of the randomness word shared by the unordered pair {i,j}, lexicographic order.
  function automatic int pair_idx(input int i, input int j);
    int lo, hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * SHARES - (lo * (lo + 1)) / 2 + (hi - lo - 1);
  endfunction

  logic                   s1_valid;
  logic [TERMS*WIDTH-1:0] term_d, s1_term;
  logic [SHARES*WIDTH-1:0] q_d;
  logic [RBITS-1:0]       rnd;
  logic                   adv, accept;

  assign adv      = !out_valid || out_ready;
  assign in_ready = !s1_valid || adv;
  assign accept   = in_valid && in_ready;

`ifdef DOM_RAND_LFSR_EN
  function automatic logic [63:0] taps64(input int n);
    case (n)
      8:       return 64'hB8;
      16:      return 64'hD008;
      24:      return 64'hE10000;
      32:      return 64'h8020_0003;
      default: return 64'h3 << (n - 2);
    endcase
  endfunction

  localparam logic [RBITS-1:0] LFSR_TAPS = RBITS'(taps64(RBITS));

  logic [RBITS-1:0] lfsr;
  logic             lfsr_fb;

  assign lfsr_fb = ^(lfsr & LFSR_TAPS);
  assign rnd     = lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      lfsr <= RBITS'(1);
    else if (accept) lfsr <= {lfsr[RBITS-2:0], lfsr_fb};
  end
`else
  assign rnd = rand_in;
`endif

  // Each stage-1 term touches at most one share of a and one share of b.
  always_comb begin
    term_d = '0;
    for (int i = 0; i < SHARES; i++) begin
      for (int j = 0; j < SHARES; j++) begin
        if (i == j)
          term_d[(i*SHARES+j)*WIDTH +: WIDTH] = a_sh[i*WIDTH +: WIDTH] & b_sh[i*WIDTH +: WIDTH];
        else
          term_d[(i*SHARES+j)*WIDTH +: WIDTH] = (a_sh[i*WIDTH +: WIDTH] & b_sh[j*WIDTH +: WIDTH])
                                                ^ rnd[pair_idx(i, j)*WIDTH +: WIDTH];
      end
    end
  end

  // Cross terms are only combined from registered values.
  always_comb begin
    q_d = '0;
    for (int i = 0; i < SHARES; i++) begin
      for (int j = 0; j < SHARES; j++) begin
        q_d[i*WIDTH +: WIDTH] = q_d[i*WIDTH +: WIDTH] ^ s1_term[(i*SHARES+j)*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_term   <= '0;
      out_valid <= 1'b0;
      q_sh      <= '0;
      op_count  <= '0;
    end else begin
      if (accept) begin
        s1_term  <= term_d;
        s1_valid <= 1'b1;
      end else if (adv) begin
        s1_valid <= 1'b0;
      end
      if (adv) begin
        out_valid <= s1_valid;
        if (s1_valid) q_sh <= q_d;
      end
      if (out_valid && out_ready) op_count <= op_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_dom_and_pipelined.sv
// Bench for dom_and_pipelined: a 2-share instance for directed vectors and a
// 3-share instance (4-bit counter) for a randomized sweep against a queue model.
module tb_dom_and_pipelined;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        iv2, ir2, ov2, or2;
  logic [15:0] a2, b2, q2, cnt2;
  logic [7:0]  r2;
  logic        iv3, ir3, ov3, or3;
  logic [23:0] a3, b3, q3, r3;
  logic [3:0]  cnt3;

  dom_and_pipelined #(.WIDTH(8), .SHARES(2), .CNT_W(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a_sh(a2), .b_sh(b2),
    .rand_in(r2), .out_valid(ov2), .out_ready(or2), .q_sh(q2), .op_count(cnt2));

  dom_and_pipelined #(.WIDTH(8), .SHARES(3), .CNT_W(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(ir3), .a_sh(a3), .b_sh(b3),
    .rand_in(r3), .out_valid(ov3), .out_ready(or3), .q_sh(q3), .op_count(cnt3));

  typedef struct {
    logic [23:0] sh;
    logic [7:0]  prod;
    int          edge_n;
  } item_t;

  item_t pq2[$], pq3[$];
  item_t it;
  int edge_cnt = 0;
  int n_checks = 0, n_fail = 0;
  int cnt_exp2 = 0, cnt_exp3 = 0, acc3 = 0, hand3 = 0;

  always @(posedge clk) edge_cnt++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] fold(input logic [23:0] x, input int ns);
    logic [7:0] f;
    f = '0;
    for (int i = 0; i < ns; i++) f ^= x[i*8 +: 8];
    return f;
  endfunction

  // Expected shares: own product plus, for every pair containing share i,
  // the cross product with the partner masked by that pair's random slice.
  function automatic logic [23:0] exp_shares(input logic [23:0] a, input logic [23:0] b,
                                             input logic [23:0] r, input int ns);
    logic [23:0] q;
    int k;
    q = '0;
    for (int i = 0; i < ns; i++) begin
      q[i*8 +: 8] = a[i*8 +: 8] & b[i*8 +: 8];
      k = 0;
      for (int p = 0; p < ns; p++) begin
        for (int s = p + 1; s < ns; s++) begin
          if (p == i || s == i)
            q[i*8 +: 8] ^= (a[i*8 +: 8] & b[((p == i) ? s : p)*8 +: 8]) ^ r[k*8 +: 8];
          k++;
        end
      end
    end
    return q;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      pq2.delete(); pq3.delete();
      cnt_exp2 = 0; cnt_exp3 = 0;
      chk("rst ov2", 32'(ov2), 0);
      chk("rst q2", 32'(q2), 0);
      chk("rst cnt3", 32'(cnt3), 0);
    end else begin
      chk("in_ready2", 32'(ir2), 32'(pq2.size() < 2 || or2));
      chk("out_valid2", 32'(ov2), 32'(pq2.size() > 0 && pq2[0].edge_n < edge_cnt));
      chk("op_count2", 32'(cnt2), 32'(cnt_exp2[15:0]));
      if (ov2 && or2 && pq2.size() > 0) begin
        chk("q2 shares", 32'(q2), 32'(pq2[0].sh[15:0]));
        chk("q2 unmasked", 32'(fold({8'h00, q2}, 2)), 32'(pq2[0].prod));
        void'(pq2.pop_front());
        cnt_exp2++;
      end
      if (iv2 && ir2) begin
        it.sh     = exp_shares({8'h00, a2}, {8'h00, b2}, {16'h0, r2}, 2);
        it.prod   = fold({8'h00, a2}, 2) & fold({8'h00, b2}, 2);
        it.edge_n = edge_cnt + 1;
        pq2.push_back(it);
      end

      chk("in_ready3", 32'(ir3), 32'(pq3.size() < 2 || or3));
      chk("out_valid3", 32'(ov3), 32'(pq3.size() > 0 && pq3[0].edge_n < edge_cnt));
      chk("op_count3", 32'(cnt3), 32'(cnt_exp3[3:0]));
      if (ov3 && or3 && pq3.size() > 0) begin
        chk("q3 shares", 32'(q3), 32'(pq3[0].sh));
        chk("q3 unmasked", 32'(fold(q3, 3)), 32'(pq3[0].prod));
        void'(pq3.pop_front());
        cnt_exp3++;
        hand3++;
      end
      if (iv3 && ir3) begin
        it.sh     = exp_shares(a3, b3, r3, 3);
        it.prod   = fold(a3, 3) & fold(b3, 3);
        it.edge_n = edge_cnt + 1;
        pq3.push_back(it);
        acc3++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    iv2 = 0; or2 = 1; a2 = '0; b2 = '0; r2 = '0;
    iv3 = 0; or3 = 1; a3 = '0; b3 = '0; r3 = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset out_valid", 32'(ov2), 0);
    chk("reset q_sh", 32'(q2), 0);
    chk("reset op_count", 32'(cnt2), 0);
    chk("reset in_ready", 32'(ir2), 1);

    // a = 0xA5, b = 0x0F, zero randomness
    @(posedge clk); #1;
    iv2 = 1; a2 = 16'h3C99; b2 = 16'h555A; r2 = 8'h00;
    @(posedge clk); #1; iv2 = 0;
    @(posedge clk); #1;
    chk("op1 out_valid", 32'(ov2), 1);
    chk("op1 q_sh", 32'(q2), 32'h0C09);
    iv2 = 1; r2 = 8'hFF;
    @(posedge clk); #1; iv2 = 0;
    @(posedge clk); #1;
    chk("op2 q_sh", 32'(q2), 32'hF3F6);
    chk("op2 unmasked", 32'(q2[15:8] ^ q2[7:0]), 32'h05);
    @(posedge clk); #1;
    chk("op2 op_count", 32'(cnt2), 2);

    // back-pressure: three bundles, sink stalled
    or2 = 0; iv2 = 1; a2 = 16'h3C99; b2 = 16'h555A; r2 = 8'h00;
    @(posedge clk); #1;
    a2 = 16'($urandom); b2 = 16'($urandom); r2 = 8'($urandom);
    @(posedge clk); #1;
    a2 = 16'($urandom); b2 = 16'($urandom); r2 = 8'($urandom);
    chk("bp in_ready low", 32'(ir2), 0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp hold q_sh", 32'(q2), 32'h0C09);
      chk("bp hold out_valid", 32'(ov2), 1);
    end
    or2 = 1;
    @(posedge clk); #1; iv2 = 0;
    repeat (4) @(posedge clk);
    #1 chk("bp op_count", 32'(cnt2), 5);

    // randomized 3-share sweep
    acc3 = 0; hand3 = 0;
    for (int c = 0; c < 20000 && acc3 < 1000; c++) begin
      iv3 = ($urandom_range(0, 9) < 7);
      or3 = ($urandom_range(0, 9) < 7);
      a3 = 24'($urandom); b3 = 24'($urandom); r3 = 24'($urandom);
      @(posedge clk); #1;
    end
    iv3 = 0; or3 = 1;
    chk("sweep accepts", 32'(acc3), 1000);
    waited = 0;
    while (pq3.size() != 0 && waited < 20) begin
      @(posedge clk); #1; waited++;
    end
    chk("sweep drained", 32'(pq3.size()), 0);
    chk("sweep one result each", 32'(hand3), 32'(acc3));

    // reset while a result is pending
    or2 = 0; iv2 = 1; a2 = 16'($urandom); b2 = 16'($urandom); r2 = 8'($urandom);
    @(posedge clk); #1; iv2 = 0;
    @(posedge clk); #1;
    chk("pre-reset out_valid", 32'(ov2), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async out_valid drop", 32'(ov2), 0);
    chk("async op_count clear", 32'(cnt2), 0);
    @(posedge clk); #1;
    rst_n = 1'b1; or2 = 1;
    iv2 = 1; a2 = 16'h3C99; b2 = 16'h555A; r2 = 8'h00;
    @(posedge clk); #1; iv2 = 0;
    @(posedge clk); #1;
    chk("post-reset q_sh", 32'(q2), 32'h0C09);
    @(posedge clk); #1;
    chk("post-reset op_count", 32'(cnt2), 1);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
